// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, width defaults and response-state encoding
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH   = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRA = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with overflow/carry/zero flags
// Ports: a, b (operands), op (opcode) -> result, overflow, carry, zero.
// Shifts take the value from b and the amount from a[4:0].
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    sum      = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[DATA_WIDTH-1:0];
        carry    = sum[DATA_WIDTH];
        overflow = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                   (result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        // a + ~b + 1: carry is the carry-out, i.e. 1 when no borrow occurred
        sum      = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
        result   = sum[DATA_WIDTH-1:0];
        carry    = sum[DATA_WIDTH];
        overflow = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                   (result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALU_SLT: result[0] = ($signed(a) < $signed(b));
      ALU_SLL: result = b << a[4:0];
      ALU_SRL: result = b >> a[4:0];
      ALU_SRA: result = $signed(b) >>> a[4:0];
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, single-entry response register
// Ports: clk, resetn (async active-low); req0/req1 valid/ready/a/b/op;
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_overflow/rsp_carry/rsp_zero.
// Build option: ALU_ARB_RR_EN selects round-robin on contention; otherwise req0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_carry,
  output logic                  rsp_zero
);

  rsp_state_t            state_q, state_d;
  logic                  last_grant;
  logic                  accept, pri0, grant0, grant1, grant;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OP_WIDTH-1:0]   alu_op;
  logic                  alu_overflow, alu_carry, alu_zero;

  assign rsp_valid = (state_q == RSP_FULL);
  assign accept    = !rsp_valid || rsp_ready;

`ifdef ALU_ARB_RR_EN
  // req0 wins contention only when req1 was granted most recently
  assign pri0 = last_grant;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pri0 = 1'b1;
`endif

  // resetn gating keeps both readies low while reset is held
  assign grant0 = resetn && accept && req0_valid && (!req1_valid || pri0);
  assign grant1 = resetn && accept && req1_valid && !grant0;
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;
  assign alu_op = grant1 ? req1_op : req0_op;

  alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .OP_WIDTH  (OP_WIDTH)
  ) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .result   (alu_result),
    .overflow (alu_overflow),
    .carry    (alu_carry),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RSP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (grant) state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !grant) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

  // Payload loads only on a handshake, so it holds while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      last_grant   <= 1'b1;
    end else if (grant) begin
      rsp_id       <= grant1;
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
      rsp_carry    <= alu_carry;
      rsp_zero     <= alu_zero;
      last_grant   <= grant1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_carry, rsp_zero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        v;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl[11];

  alu_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero)
  );

  always #5 clk = ~clk;

  // Protocol watch: requests must stay valid until ready; never both readies
  logic p0_pend = 1'b0, p1_pend = 1'b0;
  always @(posedge clk) begin
    if (resetn && p0_pend && !req0_valid) begin
      miscompares++;
      $display("FAIL req0_hold: valid=%b dropped before ready, required 1", req0_valid);
    end
    if (resetn && p1_pend && !req1_valid) begin
      miscompares++;
      $display("FAIL req1_hold: valid=%b dropped before ready, required 1", req1_valid);
    end
    if (req0_ready && req1_ready) begin
      miscompares++;
      $display("FAIL dual_ready: readies=%b%b, required at most one", req0_ready, req1_ready);
    end
    p0_pend <= resetn && req0_valid && !req0_ready;
    p1_pend <= resetn && req1_valid && !req1_ready;
  end

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, ALU_ADD, 32'd1, 32'd1);
    set1(1'b1, ALU_ADD, 32'd2, 32'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, required 00000",
               {rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero});
    end
    vectors++;
    if (rsp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h, required 00000000", rsp_result);
    end
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
    end
    set0(1'b0, ALU_AND, '0, '0);
    set1(1'b0, ALU_AND, '0, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_single_add();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set0(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL add_ready: got %b, required 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    set0(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero} !== 5'b10100) begin
      miscompares++;
      $display("FAIL add_flags: got %b, required 10100",
               {rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero});
    end
    vectors++;
    if (rsp_result !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL add_result: got %h, required 80000000", rsp_result);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_drain: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic exp_id, prev_id;
    prev_id = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    set0(1'b1, ALU_ADD, 32'd10, 32'd1);
    set1(1'b1, ALU_ADD, 32'd20, 32'd1);
    for (int i = 0; i < 6; i++) begin
      exp_id = RR ? 1'(i % 2) : 1'b0;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        miscompares++;
        $display("FAIL cont_ready[%0d]: got %b, required %b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      if (i > 0) begin
        vectors++;
        if ({rsp_valid, rsp_id} !== {1'b1, prev_id} || rsp_result !== (prev_id ? 32'd21 : 32'd11)) begin
          miscompares++;
          $display("FAIL cont_rsp[%0d]: got v=%b id=%b r=%h, required v=1 id=%b r=%h", i, rsp_valid, rsp_id,
                   rsp_result, prev_id, (prev_id ? 32'd21 : 32'd11));
        end
      end
      prev_id = exp_id;
      @(posedge clk); #1;
    end
    // retire the requester just granted; the other must win next
    if (prev_id) set1(1'b0, ALU_AND, '0, '0);
    else         set0(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== {prev_id, ~prev_id} || rsp_id !== prev_id) begin
      miscompares++;
      $display("FAIL cont_handover: got ready=%b id=%b, required ready=%b id=%b",
               {req0_ready, req1_ready}, rsp_id, {prev_id, ~prev_id}, prev_id);
    end
    @(posedge clk); #1;
    set0(1'b0, ALU_AND, '0, '0);
    set1(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id} !== {1'b1, ~prev_id} || rsp_result !== (prev_id ? 32'd11 : 32'd21)) begin
      miscompares++;
      $display("FAIL cont_last: got v=%b id=%b r=%h, required v=1 id=%b r=%h", rsp_valid, rsp_id, rsp_result,
               ~prev_id, (prev_id ? 32'd11 : 32'd21));
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set1(1'b1, ALU_SUB, 32'd5, 32'd5);
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first_ready: got %b, required 1", req1_ready);
    end
    @(posedge clk); #1;
    set1(1'b1, ALU_SUB, 32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_overflow, rsp_zero, req1_ready} !== 5'b11010 || rsp_result !== 32'h0) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: got vid_ovf_z_rdy=%b r=%h, required 11010 r=00000000", i,
                 {rsp_valid, rsp_id, rsp_overflow, rsp_zero, req1_ready}, rsp_result);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || rsp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_release: got ready=%b r=%h, required ready=1 r=00000000", req1_ready, rsp_result);
    end
    @(posedge clk); #1;
    set1(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_zero} !== 4'b1100 || rsp_result !== 32'd5) begin
      miscompares++;
      $display("FAIL bp_next: got vid_ovf_z=%b r=%h, required 1100 r=00000005",
               {rsp_valid, rsp_id, rsp_overflow, rsp_zero}, rsp_result);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    tbl[0]  = '{1'b1, ALU_SRA, 32'd4,          32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, ALU_SRL, 32'd4,          32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, ALU_SLL, 32'd31,         32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, ALU_SLL, 32'h21,         32'h3,         32'h6,         1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, ALU_SLT, 32'hFFFF_FFFF,  32'h1,         32'h1,         1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, ALU_SLT, 32'h1,          32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 32'h123,        32'h456,       32'h0,         1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, ALU_ADD, 32'hFFFF_FFFF,  32'h1,         32'h0,         1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, ALU_AND, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, ALU_OR,  32'h0F0F_0000,  32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, ALU_XOR, 32'hFFFF_0000,  32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) begin
        if (tbl[i].id) begin
          set1(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
          set0(1'b0, ALU_AND, '0, '0);
        end else begin
          set0(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
          set1(1'b0, ALU_AND, '0, '0);
        end
      end else begin
        set0(1'b0, ALU_AND, '0, '0);
        set1(1'b0, ALU_AND, '0, '0);
      end
      @(negedge clk);
      if (i < 11) begin
        vectors++;
        if ({req1_ready, req0_ready} !== (tbl[i].id ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL b2b_ready[%0d]: got r1r0=%b, required id %b granted", i, {req1_ready, req0_ready},
                   tbl[i].id);
        end
      end
      if (i > 0) begin
        vectors++;
        if ({rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero} !==
            {1'b1, tbl[i-1].id, tbl[i-1].v, tbl[i-1].c, tbl[i-1].z} || rsp_result !== tbl[i-1].r) begin
          miscompares++;
          $display("FAIL b2b_rsp[%0d]: got vidvcz=%b r=%h, required vidvcz=%b r=%h", i-1,
                   {rsp_valid, rsp_id, rsp_overflow, rsp_carry, rsp_zero}, rsp_result,
                   {1'b1, tbl[i-1].id, tbl[i-1].v, tbl[i-1].c, tbl[i-1].z}, tbl[i-1].r);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set0(1'b1, ALU_OR, 32'd3, 32'd4);
    set1(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rms_first_ready: got %b, required 1", req0_ready);
    end
    @(posedge clk); #1;
    set0(1'b1, ALU_OR, 32'd3, 32'd4);
    set1(1'b1, ALU_ADD, 32'd5, 32'd5);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL rms_stalled: got v_r0_r1=%b, required 100", {rsp_valid, req0_ready, req1_ready});
    end
    #1 resetn = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000 || rsp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL rms_in_reset: got v_r0_r1=%b r=%h, required 000 r=00000000",
               {rsp_valid, req0_ready, req1_ready}, rsp_result);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rms_first_contention: got %b, required 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    set0(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, req1_ready} !== 3'b101 || rsp_result !== 32'd7) begin
      miscompares++;
      $display("FAIL rms_rsp0: got v_id_r1=%b r=%h, required 101 r=00000007",
               {rsp_valid, rsp_id, req1_ready}, rsp_result);
    end
    @(posedge clk); #1;
    set1(1'b0, ALU_AND, '0, '0);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id} !== 2'b11 || rsp_result !== 32'd10) begin
      miscompares++;
      $display("FAIL rms_rsp1: got v_id=%b r=%h, required 11 r=0000000a", {rsp_valid, rsp_id}, rsp_result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
